// File: rtl/phys_reg_scoreboard_if.sv
// Rename/writeback/retire/query bundle between the core pipeline and the
// physical-register scoreboard.
interface phys_reg_scoreboard_if #(
    parameter int PW = 6
);
    logic          alloc_req;
    logic          alloc_ack;
    logic [PW-1:0] alloc_phys;
    logic          wb0_valid;
    logic [PW-1:0] wb0_phys;
    logic          wb1_valid;
    logic [PW-1:0] wb1_phys;
    logic          free_valid;
    logic [PW-1:0] free_phys;
    logic [PW-1:0] rs_phys;
    logic [PW-1:0] rt_phys;
    logic          rs_busy;
    logic          rt_busy;
    logic [PW-1:0] free_count;
    logic          overflow_err;

    modport master (
        output alloc_req, wb0_valid, wb0_phys, wb1_valid, wb1_phys,
               free_valid, free_phys, rs_phys, rt_phys,
        input  alloc_ack, alloc_phys, rs_busy, rt_busy, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, wb0_valid, wb0_phys, wb1_valid, wb1_phys,
               free_valid, free_phys, rs_phys, rt_phys,
        output alloc_ack, alloc_phys, rs_busy, rt_busy, free_count, overflow_err
    );
endinterface

// File: rtl/phys_reg_scoreboard.sv
// Physical-register busy table plus free-list FIFO for the renamed MIPS core.
// Allocation is granted combinationally from the free-list head; writebacks
// clear busy bits; retirement pushes superseded registers back on the tail.
module phys_reg_scoreboard #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32
) (
    input logic                 clk,
    input logic                 rst,
    phys_reg_scoreboard_if.slave sb
);
    localparam int PW = $clog2(NUM_PHYS);
    localparam int FL = NUM_PHYS - NUM_ARCH;
    localparam int HW = $clog2(FL);
    localparam int CW = $clog2(FL + 1);

    logic [NUM_PHYS-1:0] busy_q, busy_d;
    logic [PW-1:0]       fifo_q [FL];
    logic [HW-1:0]       head_q, head_d;
    logic [HW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                alloc_ok;
    logic [PW-1:0]       head_phys;
    logic                free_nz;
    logic                free_ok;
    logic                free_drop;

    function automatic logic [HW-1:0] ptr_inc(input logic [HW-1:0] p);
        return (p == HW'(FL - 1)) ? '0 : p + HW'(1);
    endfunction

    // Busy with same-cycle writeback bypass; register 0 is never busy.
    function automatic logic hazard(input logic [NUM_PHYS-1:0] b,
                                    input logic [PW-1:0] p,
                                    input logic v0, input logic [PW-1:0] p0,
                                    input logic v1, input logic [PW-1:0] p1);
        return b[p] && !(v0 && (p0 == p)) && !(v1 && (p1 == p)) && (p != '0);
    endfunction

    // Grant/accept decisions; a freed register never bypasses to an empty list.
    always_comb begin
        head_phys = fifo_q[head_q];
        alloc_ok  = sb.alloc_req && (count_q != '0);
        free_nz   = sb.free_valid && (sb.free_phys != '0);
        free_ok   = free_nz && ((count_q != CW'(FL)) || alloc_ok);
        free_drop = free_nz && (count_q == CW'(FL)) && !alloc_ok;
    end

    // Outputs show the post-reset view while rst is held, before state settles.
    always_comb begin
        sb.alloc_ack    = rst ? sb.alloc_req : alloc_ok;
        sb.alloc_phys   = rst ? PW'(NUM_ARCH) : head_phys;
        sb.rs_busy      = !rst && hazard(busy_q, sb.rs_phys, sb.wb0_valid, sb.wb0_phys,
                                         sb.wb1_valid, sb.wb1_phys);
        sb.rt_busy      = !rst && hazard(busy_q, sb.rt_phys, sb.wb0_valid, sb.wb0_phys,
                                         sb.wb1_valid, sb.wb1_phys);
        sb.free_count   = rst ? PW'(FL) : PW'(count_q);
        sb.overflow_err = !rst && ovf_q;
    end

    // Next state: clears first so a same-cycle allocation set wins.
    always_comb begin
        busy_d = busy_q;
        if (sb.wb0_valid) busy_d[sb.wb0_phys] = 1'b0;
        if (sb.wb1_valid) busy_d[sb.wb1_phys] = 1'b0;
        if (alloc_ok)     busy_d[head_phys]   = 1'b1;
        busy_d[0] = 1'b0;

        head_d  = alloc_ok ? ptr_inc(head_q) : head_q;
        tail_d  = free_ok  ? ptr_inc(tail_q) : tail_q;
        count_d = count_q - CW'(alloc_ok) + CW'(free_ok);
        ovf_d   = ovf_q | free_drop;
    end

    // State registers; reset refills the list with the non-architectural regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(FL);
            ovf_q   <= 1'b0;
            for (int i = 0; i < FL; i++) begin
                fifo_q[i] <= PW'(NUM_ARCH + i);
            end
        end else begin
            busy_q  <= busy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (free_ok) begin
                fifo_q[tail_q] <= sb.free_phys;
            end
        end
    end
endmodule

// File: tb/tb_phys_reg_scoreboard.sv
// Bench for phys_reg_scoreboard: fixed vector table, directed corner
// sequences and random traffic checked against a queue-based model.
module tb_phys_reg_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phys_reg_scoreboard_if #(.PW(6)) sb ();
    phys_reg_scoreboard #(.NUM_PHYS(64), .NUM_ARCH(32)) dut (
        .clk(clk), .rst(rst), .sb(sb)
    );

    typedef struct {
        bit rst, req, w0v; int w0p; bit w1v; int w1p; bit fv; int fp;
        int rs, rt;
        bit ack; int phys; bit rsb, rtb; int cnt; bit ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int fl[$];
    bit mbusy[64];
    bit movf;
    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit q, bit w0v, int w0p, bit w1v, int w1p,
                                bit fv, int fp, int rs, int rt,
                                bit ack, int phys, bit rsb, bit rtb, int cnt, bit ovf);
        vec_t v;
        v.rst = r; v.req = q; v.w0v = w0v; v.w0p = w0p; v.w1v = w1v; v.w1p = w1p;
        v.fv = fv; v.fp = fp; v.rs = rs; v.rt = rt;
        v.ack = ack; v.phys = phys; v.rsb = rsb; v.rtb = rtb; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        sb.alloc_req = 0; sb.wb0_valid = 0; sb.wb0_phys = 0; sb.wb1_valid = 0;
        sb.wb1_phys = 0; sb.free_valid = 0; sb.free_phys = 0;
        sb.rs_phys = 0; sb.rt_phys = 0;
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(i);
        for (int i = 0; i < 64; i++) mbusy[i] = 0;
        movf = 0;
    endtask

    function automatic int model_busy(input int p);
        if (p == 0 || !mbusy[p]) return 0;
        if (sb.wb0_valid && int'(sb.wb0_phys) == p) return 0;
        if (sb.wb1_valid && int'(sb.wb1_phys) == p) return 0;
        return 1;
    endfunction

    // One clock: compare outputs with the model, take the edge, advance the model.
    task automatic cyc(input string tag);
        int eack;
        int n;
        int p;
        #1;
        eack = 0;
        if (rst) begin
            chk({tag, ".ack"},  sb.alloc_ack, sb.alloc_req);
            chk({tag, ".phys"}, sb.alloc_phys, 32);
            chk({tag, ".rsb"},  sb.rs_busy, 0);
            chk({tag, ".rtb"},  sb.rt_busy, 0);
            chk({tag, ".cnt"},  sb.free_count, 32);
            chk({tag, ".ovf"},  sb.overflow_err, 0);
        end else begin
            eack = (sb.alloc_req && fl.size() != 0) ? 1 : 0;
            chk({tag, ".ack"}, sb.alloc_ack, eack);
            if (fl.size() != 0) chk({tag, ".phys"}, sb.alloc_phys, fl[0]);
            chk({tag, ".rsb"}, sb.rs_busy, model_busy(int'(sb.rs_phys)));
            chk({tag, ".rtb"}, sb.rt_busy, model_busy(int'(sb.rt_phys)));
            chk({tag, ".cnt"}, sb.free_count, fl.size());
            chk({tag, ".ovf"}, sb.overflow_err, movf);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            n = fl.size();
            p = 0;
            if (eack != 0) p = fl.pop_front();
            if (sb.free_valid && sb.free_phys != 0) begin
                if (n != 32 || eack != 0) fl.push_back(int'(sb.free_phys));
                else movf = 1;
            end
            if (sb.wb0_valid) mbusy[sb.wb0_phys] = 0;
            if (sb.wb1_valid) mbusy[sb.wb1_phys] = 0;
            if (eack != 0) mbusy[p] = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; cyc("rst"); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        @(negedge clk);

        //        rst req w0v w0p w1v w1p fv fp  rs  rt  ack phys rsb rtb cnt ovf
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0,  5,  0,  1, 32, 0, 0, 32, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0,  0,  0,  0, 32, 0, 0, 32, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  32, 63, 0, 32, 0, 0, 32, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  32, 0,  1, 32, 0, 0, 32, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  32, 33, 0, 33, 1, 0, 31, 0));
        vecs.push_back(mk(0, 0, 1, 32, 0, 0,  0, 0,  32, 32, 0, 33, 0, 0, 31, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  32, 0,  0, 33, 0, 0, 31, 0));
        vecs.push_back(mk(0, 1, 1, 33, 0, 0,  0, 0,  33, 0,  1, 33, 0, 0, 31, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  33, 0,  0, 34, 1, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 33, 1, 45, 33, 33, 0, 34, 0, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  1, 0,  33, 0,  0, 34, 0, 0, 31, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  1, 46, 0,  0,  1, 34, 0, 0, 31, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0,  34, 34, 0, 35, 1, 1, 31, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            sb.alloc_req  = vecs[i].req;
            sb.wb0_valid  = vecs[i].w0v; sb.wb0_phys = 6'(vecs[i].w0p);
            sb.wb1_valid  = vecs[i].w1v; sb.wb1_phys = 6'(vecs[i].w1p);
            sb.free_valid = vecs[i].fv;  sb.free_phys = 6'(vecs[i].fp);
            sb.rs_phys    = 6'(vecs[i].rs); sb.rt_phys = 6'(vecs[i].rt);
            #1;
            chk($sformatf("vec%0d.ack", i),  sb.alloc_ack, vecs[i].ack);
            chk($sformatf("vec%0d.phys", i), sb.alloc_phys, vecs[i].phys);
            chk($sformatf("vec%0d.rsb", i),  sb.rs_busy, vecs[i].rsb);
            chk($sformatf("vec%0d.rtb", i),  sb.rt_busy, vecs[i].rtb);
            chk($sformatf("vec%0d.cnt", i),  sb.free_count, vecs[i].cnt);
            chk($sformatf("vec%0d.ovf", i),  sb.overflow_err, vecs[i].ovf);
            cyc($sformatf("vec%0d", i));
        end
        rst = 0; idle();

        // Reset state, every query index.
        rst = 1; cyc("rs0"); cyc("rs1"); rst = 0;
        #1;
        chk("reset.cnt", sb.free_count, 32);
        chk("reset.phys", sb.alloc_phys, 32);
        chk("reset.ovf", sb.overflow_err, 0);
        for (int p = 0; p < 64; p++) begin
            sb.rs_phys = 6'(p); sb.rt_phys = 6'(63 - p); #1;
            chk($sformatf("reset.rsb%0d", p), sb.rs_busy, 0);
            chk($sformatf("reset.rtb%0d", p), sb.rt_busy, 0);
        end
        idle(); @(negedge clk);

        // Drain, empty, refill across the pointer wrap.
        for (int i = 0; i < 32; i++) begin
            sb.alloc_req = 1; #1;
            chk($sformatf("drain%0d.ack", i), sb.alloc_ack, 1);
            chk($sformatf("drain%0d.phys", i), sb.alloc_phys, 32 + i);
            cyc("drain");
        end
        #1;
        chk("empty.ack", sb.alloc_ack, 0);
        chk("empty.cnt", sb.free_count, 0);
        cyc("empty");
        sb.alloc_req = 0; sb.free_valid = 1; sb.free_phys = 40; cyc("fr40");
        sb.free_phys = 41; cyc("fr41");
        sb.free_valid = 0; #1;
        chk("refill.cnt", sb.free_count, 2);
        sb.alloc_req = 1; #1;
        chk("wrap.phys40", sb.alloc_phys, 40);
        cyc("wrap0"); #1;
        chk("wrap.phys41", sb.alloc_phys, 41);
        cyc("wrap1");
        sb.free_valid = 1; sb.free_phys = 50; #1;
        chk("nobypass.ack", sb.alloc_ack, 0);
        cyc("nobypass");
        sb.free_valid = 0; sb.alloc_req = 0; #1;
        chk("nobypass.cnt", sb.free_count, 1);
        sb.alloc_req = 1; sb.free_valid = 1; sb.free_phys = 51; #1;
        chk("swap.ack", sb.alloc_ack, 1);
        chk("swap.phys", sb.alloc_phys, 50);
        cyc("swap");
        sb.free_valid = 0; sb.alloc_req = 0; #1;
        chk("swap.cnt", sb.free_count, 1);
        chk("swap.next", sb.alloc_phys, 51);
        idle();

        // Busy lifecycle with bypass and dual-port clears.
        do_reset();
        sb.alloc_req = 1; cyc("b_alloc32"); sb.alloc_req = 0;
        sb.rs_phys = 32; #1;
        chk("busy32.set", sb.rs_busy, 1);
        sb.wb0_valid = 1; sb.wb0_phys = 32; #1;
        chk("busy32.bypass", sb.rs_busy, 0);
        cyc("b_wb32");
        sb.wb0_valid = 0; #1;
        chk("busy32.cleared", sb.rs_busy, 0);
        do_reset();
        sb.alloc_req = 1; cyc("b_a32"); cyc("b_a33"); sb.alloc_req = 0;
        sb.rs_phys = 32; sb.rt_phys = 33; #1;
        chk("dual.rs_pre", sb.rs_busy, 1);
        chk("dual.rt_pre", sb.rt_busy, 1);
        sb.wb1_valid = 1; sb.wb1_phys = 32; sb.wb0_valid = 1; sb.wb0_phys = 33;
        cyc("dual");
        sb.wb0_valid = 0; sb.wb1_valid = 0; #1;
        chk("dual.rs_post", sb.rs_busy, 0);
        chk("dual.rt_post", sb.rt_busy, 0);
        sb.alloc_req = 1; sb.wb0_valid = 1; sb.wb0_phys = 34; cyc("setwins");
        idle(); sb.rs_phys = 34; #1;
        chk("setwins.busy", sb.rs_busy, 1);

        // Overflow on a full list, sticky until reset.
        do_reset();
        sb.free_valid = 1; sb.free_phys = 45; cyc("ovf"); idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ovf.sticky", sb.overflow_err, 1);
            chk("ovf.cnt", sb.free_count, 32);
            cyc("ovf_hold");
        end
        do_reset(); #1;
        chk("ovf.cleared", sb.overflow_err, 0);

        // Free of register 0 ignored; query of 0 never busy.
        sb.alloc_req = 1;
        for (int i = 0; i < 27; i++) cyc("to5");
        sb.alloc_req = 0; sb.free_valid = 1; sb.free_phys = 0; cyc("free0");
        idle(); #1;
        chk("free0.cnt", sb.free_count, 5);
        chk("free0.ovf", sb.overflow_err, 0);
        chk("q0.rsb", sb.rs_busy, 0);

        // Reset in the middle of traffic.
        do_reset();
        sb.alloc_req = 1;
        for (int i = 0; i < 10; i++) cyc("pre_rst");
        idle();
        for (int p = 32; p < 42; p++) begin
            sb.rs_phys = 6'(p); #1;
            chk($sformatf("prerst.busy%0d", p), sb.rs_busy, 1);
        end
        idle(); @(negedge clk);
        rst = 1; sb.alloc_req = 1; sb.free_valid = 1; sb.free_phys = 40; cyc("midrst");
        rst = 0; idle(); #1;
        chk("midrst.cnt", sb.free_count, 32);
        chk("midrst.phys", sb.alloc_phys, 32);
        for (int p = 0; p < 64; p++) begin
            sb.rs_phys = 6'(p); #1;
            chk($sformatf("midrst.busy%0d", p), sb.rs_busy, 0);
        end
        idle(); @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            sb.alloc_req  = ($urandom_range(0, 1) == 1);
            sb.wb0_valid  = ($urandom_range(0, 2) == 0);
            sb.wb0_phys   = 6'($urandom_range(0, 63));
            sb.wb1_valid  = ($urandom_range(0, 2) == 0);
            sb.wb1_phys   = 6'($urandom_range(0, 63));
            sb.free_valid = ($urandom_range(0, 9) < 4);
            sb.free_phys  = 6'($urandom_range(0, 63));
            sb.rs_phys    = 6'($urandom_range(0, 63));
            sb.rt_phys    = 6'($urandom_range(0, 63));
            cyc("rnd");
        end
        rst = 0; idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/phys_reg_scoreboard.md
Name: phys_reg_scoreboard

Overview:
- Owns the physical-register busy table and the free list for the renamed MIPS core.
- The rename stage allocates a destination physical register from the free list and marks it busy.
- Writeback ports clear busy bits. Retirement returns superseded registers to the free list.
- Combinational query ports give the forwarding/hazard logic per-operand busy status, with same-cycle writeback bypass.

Parameters:
- NUM_PHYS, 64, number of physical registers; phys index width PW = $clog2(NUM_PHYS) = 6.
- NUM_ARCH, 32, number of architectural registers; free-list depth FL = NUM_PHYS - NUM_ARCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alloc_req  in  1  rename requests one destination register this cycle
- alloc_ack  out  1  allocation granted this cycle (combinational)
- alloc_phys  out  PW  granted physical register (head of free list); valid when alloc_ack
- wb0_valid  in  1  writeback port 0 (EX result) valid
- wb0_phys  in  PW  register written by port 0
- wb1_valid  in  1  writeback port 1 (MEM/WB result) valid
- wb1_phys  in  PW  register written by port 1
- free_valid  in  1  retire returns a physical register to the free list
- free_phys  in  PW  register being returned
- rs_phys  in  PW  query operand rs
- rt_phys  in  PW  query operand rt
- rs_busy  out  1  rs result not yet available (combinational)
- rt_busy  out  1  rt result not yet available (combinational)
- free_count  out  PW  entries currently in free list, range 0..FL
- overflow_err  out  1  sticky: a free was dropped because the list was full

Behaviour:
- **State:**
  - busy[NUM_PHYS] bit vector.
  - Free-list FIFO of FL entries, each PW bits wide.
  - head_ptr and tail_ptr, each $clog2(FL) bits, wrapping modulo FL.
  - count, 0..FL.
- **Reset (synchronous, rst=1 at a clock edge):**
  - busy all 0.
  - FIFO entries i = 0..FL-1 hold NUM_ARCH+i, i.e. 32..63.
  - head_ptr = 0, tail_ptr = 0, count = FL.
  - overflow_err = 0.
  - Reset mid-operation discards all in-flight allocations and frees. Inputs sampled in the reset cycle are ignored.
- **Outputs while rst=1 and in the first cycle after reset:**
  - alloc_ack = alloc_req, since the list is full.
  - alloc_phys = 32.
  - rs_busy = rt_busy = 0.
  - free_count = FL.
  - overflow_err = 0.
- **Allocate:**
  - alloc_ack = alloc_req & (count != 0). alloc_phys = fifo[head_ptr], driven even when there is no request.
  - On a clock edge with alloc_ack: head_ptr++ (wraps FL-1 to 0), and busy[alloc_phys] is set.
  - Zero-cycle grant. Busy becomes visible on the query ports the next cycle.
- **Writeback:**
  - On a clock edge, wbX_valid clears busy[wbX_phys].
  - Both ports may target different registers in the same cycle.
  - The same register on both ports clears it once.
- **Set-over-clear priority:** if alloc_ack and a writeback target the same register in the same cycle, the set wins and busy ends at 1.
- **Free:**
  - On a clock edge with free_valid and free_phys != 0 and (count != FL or alloc_ack): write fifo[tail_ptr] = free_phys and tail_ptr++ (wraps).
  - With free_valid, free_phys != 0, count == FL and no alloc_ack: drop the entry and set overflow_err (sticky until reset).
- **No bypass when empty:** a freed register is not allocatable in the same cycle. If count == 0, alloc_ack = 0 even if free_valid = 1.
- **Count update:** count_next = count - alloc_ack + (free accepted). Simultaneous alloc+free leaves count unchanged.
- **Register 0:**
  - Phys 0 is never on the free list; frees of 0 are ignored with no error.
  - busy[0] is never set; writes to bit 0 are ignored.
  - Queries of 0 return 0.
- **Query (combinational):**
  - rs_busy = busy[rs_phys] & ~(wb0_valid & wb0_phys==rs_phys) & ~(wb1_valid & wb1_phys==rs_phys) & (rs_phys != 0).
  - rt_busy is the same expression using rt_phys.
  - The same-cycle allocation is not reflected in queries.
- **free_count:** equals count (registered).

Test Plan:
- **Reset state:** rst=1 for 2 cycles, then idle → free_count=32, alloc_phys=32, rs_busy=rt_busy=0 for every rs_phys 0..63, overflow_err=0.
- **Drain and refill with wrap:**
  - 32 consecutive alloc_req → alloc_phys 32,33,…,63, each with alloc_ack=1.
  - 33rd request → alloc_ack=0, free_count=0.
  - Then free 40,41 → free_count=2.
  - Next allocs return 40 then 41, exercising head_ptr wrap 31→0.
- **Busy lifecycle:**
  - Alloc 32 → next cycle rs_phys=32 gives rs_busy=1.
  - Assert wb0_valid, wb0_phys=32 → rs_busy=0 in the same cycle (bypass) and stays 0 after the edge.
  - wb1 with phys 32 and wb0 with phys 33 together → both cleared.
- **Simultaneous events:**
  - At count=0, free_valid with phys=50 and alloc_req → alloc_ack=0, count=1 next cycle.
  - At count=1, alloc+free together → count stays 1, and the freed value is returned after the current head.
  - Alloc of X with wb0 of X in the same cycle → busy[X]=1.
- **Boundary errors:**
  - At count=32, free_phys=45 → entry dropped, overflow_err=1, stays 1 until reset.
  - Free of phys 0 at count=5 → count stays 5, overflow_err unchanged.
  - Query rs_phys=0 → rs_busy=0.
- **Reset mid-operation:**
  - After 10 allocs with regs 32..41 busy, assert rst together with alloc_req and free_valid → next cycle matches the reset state exactly: free_count=32, alloc_phys=32, no busy bits.
